// File: rtl/nf10_axis_stream_monitor.sv
// AXI4-Stream sink/monitor: packet/beat/byte counters, first-beat tuser capture,
// activity stretch and protocol checker. Define NF10_AXIS_MONITOR_BACKPRESSURE_EN for LFSR backpressure.
module nf10_axis_stream_monitor #(
  parameter int          C_S_AXIS_DATA_WIDTH  = 256,
  parameter int          C_S_AXIS_TUSER_WIDTH = 128,
  parameter int          C_COUNTER_WIDTH      = 32,
  parameter int          C_ACTIVITY_HOLD      = 16,
  parameter logic [15:0] C_LFSR_SEED          = 16'hACE1
) (
  input  logic                              aclk,
  input  logic                              reset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  input  logic                              clear,
  output logic [C_COUNTER_WIDTH-1:0]        pkt_count,
  output logic [C_COUNTER_WIDTH-1:0]        beat_count,
  output logic [C_COUNTER_WIDTH-1:0]        byte_count,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   last_tuser,
  output logic                              in_packet,
  output logic                              activity_rec,
  output logic [1:0]                        proto_err
);
  localparam int SW  = C_S_AXIS_DATA_WIDTH / 8;
  localparam int PW  = $clog2(SW + 1);
  localparam int AW  = ((C_COUNTER_WIDTH > PW) ? C_COUNTER_WIDTH : PW) + 1;
  localparam int HW  = $clog2(C_ACTIVITY_HOLD + 1);
  localparam int PLW = C_S_AXIS_DATA_WIDTH + SW + C_S_AXIS_TUSER_WIDTH + 1;
  localparam logic [C_COUNTER_WIDTH-1:0] CMAX = '1;

  typedef enum logic {IDLE, IN_PKT} state_t;

  logic                       acc;
  logic [PW-1:0]              strb_ones;
  logic [C_COUNTER_WIDTH-1:0] pkt_base, beat_base, byte_base;
  logic [AW-1:0]              byte_sum;
  logic [HW-1:0]              hold;
  logic [PLW-1:0]             payload, held;
  logic                       pend;
  logic [1:0]                 err_now;
  state_t                     state;

  assign acc = s_axis_tvalid & s_axis_tready;

  always_comb begin
    strb_ones = '0;
    for (int i = 0; i < SW; i++) strb_ones = strb_ones + PW'(s_axis_tstrb[i]);
  end

  // clear rebases the counters so a coincident beat lands on zero
  assign pkt_base  = clear ? '0 : pkt_count;
  assign beat_base = clear ? '0 : beat_count;
  assign byte_base = clear ? '0 : byte_count;
  assign byte_sum  = AW'(byte_base) + AW'(strb_ones);

  function automatic logic [C_COUNTER_WIDTH-1:0] sat_inc(input logic [C_COUNTER_WIDTH-1:0] v);
    return (v == CMAX) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      pkt_count  <= '0;
      beat_count <= '0;
      byte_count <= '0;
    end else begin
      pkt_count  <= (acc && s_axis_tlast) ? sat_inc(pkt_base) : pkt_base;
      beat_count <= acc ? sat_inc(beat_base) : beat_base;
      if (acc)
        byte_count <= (byte_sum > AW'(CMAX)) ? CMAX : byte_sum[C_COUNTER_WIDTH-1:0];
      else
        byte_count <= byte_base;
    end
  end

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      in_packet  <= 1'b0;
      last_tuser <= '0;
    end else if (acc) begin
      case (state)
        IDLE: begin
          last_tuser <= s_axis_tuser;
          if (!s_axis_tlast) begin
            state     <= IN_PKT;
            in_packet <= 1'b1;
          end
        end
        IN_PKT: begin
          if (s_axis_tlast) begin
            state     <= IDLE;
            in_packet <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_packet <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge aclk or posedge reset) begin
    if (reset)    hold <= '0;
    else if (acc) hold <= HW'(C_ACTIVITY_HOLD);
    else if (hold != '0) hold <= hold - HW'(1);
  end
  assign activity_rec = (hold != '0);

  // A beat offered but not taken must come back unchanged and still valid
  assign payload = {s_axis_tdata, s_axis_tstrb, s_axis_tuser, s_axis_tlast};
  assign err_now = {pend & (payload != held), pend & ~s_axis_tvalid};

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      pend      <= 1'b0;
      held      <= '0;
      proto_err <= 2'b00;
    end else begin
      pend      <= s_axis_tvalid & ~s_axis_tready;
      held      <= payload;
      proto_err <= (clear ? 2'b00 : proto_err) | err_now;
    end
  end

`ifdef NF10_AXIS_MONITOR_BACKPRESSURE_EN
  logic [15:0] lfsr;
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      lfsr          <= C_LFSR_SEED;
      s_axis_tready <= 1'b0;
    end else begin
      lfsr          <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      s_axis_tready <= lfsr[0] | lfsr[1];
    end
  end
`else
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) s_axis_tready <= 1'b0;
    else       s_axis_tready <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_nf10_axis_stream_monitor.sv
// Bench for nf10_axis_stream_monitor: directed table, corner sequences and
// randomized traffic against a behavioural model; a 4-bit-counter copy checks saturation.
module tb_nf10_axis_stream_monitor;
  localparam int HOLD = 16;

  logic         aclk = 1'b0;
  logic         reset = 1'b1;
  logic [255:0] tdata = '0;
  logic [31:0]  tstrb = '0;
  logic [127:0] tuser = '0;
  logic         tvalid = 1'b0, tlast = 1'b0, clear = 1'b0;

  logic         tready, tready4;
  logic [31:0]  pkt, beat, bytes;
  logic [3:0]   pkt4, beat4, bytes4;
  logic [127:0] lt, lt4;
  logic         inp, inp4, act, act4;
  logic [1:0]   perr, perr4;

  nf10_axis_stream_monitor dut (
    .aclk(aclk), .reset(reset), .s_axis_tdata(tdata), .s_axis_tstrb(tstrb),
    .s_axis_tuser(tuser), .s_axis_tvalid(tvalid), .s_axis_tready(tready),
    .s_axis_tlast(tlast), .clear(clear), .pkt_count(pkt), .beat_count(beat),
    .byte_count(bytes), .last_tuser(lt), .in_packet(inp), .activity_rec(act),
    .proto_err(perr));

  nf10_axis_stream_monitor #(.C_COUNTER_WIDTH(4)) dut4 (
    .aclk(aclk), .reset(reset), .s_axis_tdata(tdata), .s_axis_tstrb(tstrb),
    .s_axis_tuser(tuser), .s_axis_tvalid(tvalid), .s_axis_tready(tready4),
    .s_axis_tlast(tlast), .clear(clear), .pkt_count(pkt4), .beat_count(beat4),
    .byte_count(bytes4), .last_tuser(lt4), .in_packet(inp4), .activity_rec(act4),
    .proto_err(perr4));

  always #5 aclk = ~aclk;

  int passed = 0, total = 0;

  // behavioural model
  longint unsigned m_pkt[2], m_beat[2], m_byte[2];
  longint unsigned m_max[2] = '{64'hFFFF_FFFF, 64'd15};
  logic [127:0] m_tuser;
  bit           m_inpkt, m_rdy, m_pend;
  logic [416:0] m_held;
  logic [1:0]   m_err;
  int           m_cyc = 0, m_lastacc = -1000000;
  logic [15:0]  m_lfsr;

  task automatic chk(input string name, input logic [127:0] a, input logic [127:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, a, e, $time);
  endtask

  function automatic longint unsigned sat(input longint unsigned v, input longint unsigned d,
                                          input longint unsigned mx);
    return (v + d > mx) ? mx : v + d;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin m_pkt[k] = 0; m_beat[k] = 0; m_byte[k] = 0; end
    m_tuser = '0; m_inpkt = 0; m_rdy = 0; m_pend = 0; m_held = '0; m_err = 2'b00;
    m_lastacc = -1000000; m_lfsr = 16'hACE1;
  endtask

  task automatic model_edge();
    bit acc;
    logic [416:0] pl;
    logic [1:0] e;
    pl  = {tdata, tstrb, tuser, tlast};
    acc = tvalid && m_rdy;
    e   = {m_pend && (pl != m_held), m_pend && !tvalid};
    for (int k = 0; k < 2; k++) begin
      if (clear) begin m_pkt[k] = 0; m_beat[k] = 0; m_byte[k] = 0; end
      if (acc) begin
        m_beat[k] = sat(m_beat[k], 1, m_max[k]);
        m_byte[k] = sat(m_byte[k], longint'($countones(tstrb)), m_max[k]);
        if (tlast) m_pkt[k] = sat(m_pkt[k], 1, m_max[k]);
      end
    end
    m_err = (clear ? 2'b00 : m_err) | e;
    if (acc) begin
      if (!m_inpkt) m_tuser = tuser;
      m_inpkt = !tlast;
    end
    m_cyc++;
    if (acc) m_lastacc = m_cyc;
    m_pend = tvalid && !m_rdy;
    m_held = pl;
`ifdef NF10_AXIS_MONITOR_BACKPRESSURE_EN
    m_rdy  = m_lfsr[0] | m_lfsr[1];
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
`else
    m_rdy = 1;
`endif
  endtask

  task automatic check_all();
    chk("tready", tready, m_rdy);
    chk("tready4", tready4, m_rdy);
    chk("pkt_count", pkt, m_pkt[0]);
    chk("beat_count", beat, m_beat[0]);
    chk("byte_count", bytes, m_byte[0]);
    chk("pkt_count4", pkt4, m_pkt[1]);
    chk("beat_count4", beat4, m_beat[1]);
    chk("byte_count4", bytes4, m_byte[1]);
    chk("last_tuser", lt, m_tuser);
    chk("in_packet", inp, m_inpkt);
    chk("activity_rec", act, (m_cyc - m_lastacc) < HOLD);
    chk("proto_err", perr, m_err);
  endtask

  task automatic step();
    model_edge();
    @(posedge aclk);
    @(negedge aclk);
    check_all();
  endtask

  task automatic do_reset();
    tvalid = 0; clear = 0; reset = 1;
    #1;
    model_reset();
    check_all();
    @(posedge aclk);
    @(negedge aclk);
    reset = 0;
  endtask

  task automatic send_beat(input logic last, input logic [31:0] strb,
                           input logic [127:0] user, input logic clr);
    bit done;
    done = 0;
    tvalid = 1; tlast = last; tstrb = strb; tuser = user; clear = clr;
    tdata = {8{$urandom}};
    for (int i = 0; i < 64 && !done; i++) begin
      done = m_rdy;
      step();
    end
    clear = 0;
    if (!done) begin
      total++;
      $display("FAIL handshake_timeout: got no accept expected accept within 64 cycles");
    end
  endtask

  typedef struct {
    logic         l, clr;
    logic [31:0]  strb;
    logic [127:0] user;
    int           e_pkt, e_beat, e_byte;
    logic         e_inp;
    logic [127:0] e_tu;
  } vec_t;
  vec_t tbl[6];

  initial begin
    int cnt;
    tbl[0] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 128'h55, 0, 1,  32, 1'b1, 128'h55};
    tbl[1] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 128'h11, 0, 2,  64, 1'b1, 128'h55};
    tbl[2] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 128'h22, 0, 3,  96, 1'b1, 128'h55};
    tbl[3] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 128'h33, 1, 4, 128, 1'b0, 128'h55};
    tbl[4] = '{1'b1, 1'b0, 32'h0000_000F, 128'h66, 2, 5, 132, 1'b0, 128'h66};
    tbl[5] = '{1'b1, 1'b1, 32'h0000_00FF, 128'h77, 1, 1,   8, 1'b0, 128'h77};

    @(negedge aclk);
    do_reset();

    // 4-beat packet, single-beat packet, clear coincident with a tlast beat
    for (int i = 0; i < 6; i++) begin
      send_beat(tbl[i].l, tbl[i].strb, tbl[i].user, tbl[i].clr);
      chk($sformatf("tbl%0d_pkt", i), pkt, tbl[i].e_pkt);
      chk($sformatf("tbl%0d_beat", i), beat, tbl[i].e_beat);
      chk($sformatf("tbl%0d_byte", i), bytes, tbl[i].e_byte);
      chk($sformatf("tbl%0d_inpkt", i), inp, tbl[i].e_inp);
      chk($sformatf("tbl%0d_tuser", i), lt, tbl[i].e_tu);
    end

    // activity stretch after the last beat
    cnt = act ? 1 : 0;
    tvalid = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (act) cnt++;
      else break;
    end
    chk("activity_len", cnt, HOLD);

    // saturation on the 4-bit copy
    do_reset();
    for (int i = 0; i < 20; i++) send_beat(1'b1, 32'h0000_000F, 128'(i), 1'b0);
    tvalid = 0;
    step();
    chk("sat_pkt4", pkt4, 4'd15);
    chk("sat_byte4", bytes4, 4'd15);
    chk("sat_pkt32", pkt, 32'd20);

    // reset mid-packet, then a fresh 3-beat packet
    do_reset();
    send_beat(1'b0, 32'hFF, 128'h01, 1'b0);
    send_beat(1'b0, 32'hFF, 128'h02, 1'b0);
    do_reset();
    send_beat(1'b0, 32'hF, 128'hAA, 1'b0);
    send_beat(1'b0, 32'hF, 128'hBB, 1'b0);
    send_beat(1'b1, 32'hF, 128'hCC, 1'b0);
    tvalid = 0;
    step();
    chk("rst_pkt", pkt, 32'd1);
    chk("rst_beat", beat, 32'd3);
    chk("rst_tuser", lt, 128'hAA);

    // protocol checker: the first cycle after reset release has tready low
    do_reset();
    tvalid = 1; tlast = 1; tstrb = 32'h1; tuser = 128'h5; tdata = 256'h1234;
    step();
    tdata = 256'h5678;
    step();
    tvalid = 0;
    step();
    step();
    chk("perr_data_change", perr, 2'b10);
    do_reset();
    tvalid = 1; tdata = 256'h9;
    step();
    tvalid = 0;
    step();
    chk("perr_valid_drop", perr, 2'b01);
    clear = 1;
    step();
    clear = 0;
    chk("perr_clear", perr, 2'b00);

    // randomized traffic, mostly protocol-clean
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
        continue;
      end
      if (!(m_pend && $urandom_range(0, 49) != 0)) begin
        tvalid = ($urandom_range(0, 9) < 7);
        tlast  = ($urandom_range(0, 3) == 0);
        case ($urandom_range(0, 3))
          0: tstrb = '0;
          1: tstrb = '1;
          2: tstrb = $urandom;
          default: tstrb = 32'hFFFF_FFFF >> $urandom_range(0, 31);
        endcase
        tuser = {4{$urandom}};
        tdata = {8{$urandom}};
      end
      clear = ($urandom_range(0, 49) == 0);
      step();
    end
    clear = 0;
    tvalid = 0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
